// File: rtl/mem_port_arbiter.sv
// Phase-gated arbiter sharing one single-port memory between calc (r/w) and display (read-only).
// Define ARB_ACCESS_CNT_EN to enable the per-port saturating grant counters on c_cnt/d_cnt.
module mem_port_arbiter #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    phase,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    input  logic          d_req,
    input  logic [AW-1:0] d_addr,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [15:0]   c_cnt,
    output logic [15:0]   d_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_C = 2'd1;
    localparam logic [1:0] GNT_D = 2'd2;

    localparam int            HW       = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    logic [1:0]    state_reg, state_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          mem_we_reg, mem_we_next;
    logic [AW-1:0] mem_addr_reg, mem_addr_next;
    logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
    logic          c_rv_reg, d_rv_reg;
    logic          c_ok, d_ok, c_pri, starve;

    // hold_reg counts contested wins by the priority side; any other outcome restarts the run.
    always_comb begin
        c_ok       = c_req && (phase == 2'd1 || phase == 2'd2);
        d_ok       = d_req && (phase == 2'd1 || phase == 2'd2);
        c_pri      = (phase == 2'd1);
        starve     = 1'b0;
        hold_next  = '0;
        state_next = IDLE;
        if (c_ok && d_ok) begin
            starve     = (hold_reg >= HOLD_LIM);
            hold_next  = starve ? '0 : hold_reg + 1'b1;
            state_next = (c_pri ^ starve) ? GNT_C : GNT_D;
        end else if (c_ok) begin
            state_next = GNT_C;
        end else if (d_ok) begin
            state_next = GNT_D;
        end

        mem_we_next    = 1'b0;
        mem_addr_next  = '0;
        mem_wdata_next = '0;
        case (state_next)
            GNT_C: begin
                mem_we_next    = c_we;
                mem_addr_next  = c_addr;
                mem_wdata_next = c_wdata;
            end
            GNT_D: mem_addr_next = d_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            c_rv_reg      <= 1'b0;
            d_rv_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            // Launched from the granted access itself, so a phase change cannot cancel it.
            c_rv_reg      <= (state_reg == GNT_C) && !mem_we_reg;
            d_rv_reg      <= (state_reg == GNT_D);
        end
    end

    assign c_gnt     = (state_reg == GNT_C);
    assign d_gnt     = (state_reg == GNT_D);
    assign mem_en    = c_gnt | d_gnt;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign c_rvalid  = c_rv_reg;
    assign d_rvalid  = d_rv_reg;
    assign rdata     = (c_rv_reg | d_rv_reg) ? mem_rdata : '0;
    assign busy      = mem_en | c_rv_reg | d_rv_reg;

`ifdef ARB_ACCESS_CNT_EN
    logic [1:0] gnt_vec;
    assign gnt_vec = {d_gnt, c_gnt};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_reg <= '0;
                end else if (gnt_vec[gi] && cnt_reg != 16'hFFFF) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign c_cnt = g_cnt[0].cnt_reg;
    assign d_cnt = g_cnt[1].cnt_reg;
`else
    assign c_cnt = '0;
    assign d_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a cycle-level reference model.
// Expected counter values follow ARB_ACCESS_CNT_EN the same way the design does.
module tb_mem_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int HOLD_MAX = 4;
    localparam int NONE = 0, GC = 1, GD = 2;
    localparam int S_CGNT = 0, S_DGNT = 1, S_CRV = 2, S_DRV = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    phase = '0;
    logic          c_req = 1'b0, c_we = 1'b0, d_req = 1'b0;
    logic [AW-1:0] c_addr = '0, d_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [DW-1:0] rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic [15:0]   c_cnt, d_cnt;

    mem_port_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(HOLD_MAX)) dut (
        .clk(clk), .rst(rst), .phase(phase),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
        .c_cnt(c_cnt), .d_cnt(d_cnt)
    );

    always #5 clk = ~clk;

    // The memory being shared: synchronous, one cycle read latency.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Stimulus staged here, applied to the DUT inputs once per cycle.
    logic [1:0]    drv_phase = '0;
    logic          drv_c_req = 1'b0, drv_c_we = 1'b0, drv_d_req = 1'b0;
    logic [AW-1:0] drv_c_addr = '0, drv_d_addr = '0;
    logic [DW-1:0] drv_c_wdata = '0;

    // Reference model: expected behaviour of the cycle currently on the outputs.
    logic [DW-1:0] ref_mem [16];
    int            exp_gnt = NONE;
    logic          exp_we = 1'b0, exp_rv_c = 1'b0, exp_rv_d = 1'b0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_wdata = '0, exp_rdata = '0;
    logic [15:0]   exp_ccnt = '0, exp_dcnt = '0;
    int            streak = 0;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [63:0] out_vec();
        return {5'd0, c_gnt, c_rvalid, d_gnt, d_rvalid, rdata, mem_en, mem_we,
                mem_addr, mem_wdata, busy, c_cnt, d_cnt};
    endfunction

    function automatic logic [31:0] exp_cnt_vec();
`ifdef ARB_ACCESS_CNT_EN
        return {exp_ccnt, exp_dcnt};
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            S_CGNT:  return c_gnt;
            S_DGNT:  return d_gnt;
            S_CRV:   return c_rvalid;
            default: return d_rvalid;
        endcase
    endfunction

    task automatic check_outputs();
        logic ew;
        logic erv;
        ew  = (exp_gnt == GC) && exp_we;
        erv = exp_rv_c | exp_rv_d;
        chk("gnt", {c_gnt, d_gnt}, {exp_gnt == GC, exp_gnt == GD});
        chk("mem", {mem_en, mem_en & mem_we, mem_en ? mem_addr : 4'h0, (mem_en & mem_we) ? mem_wdata : 8'h00},
                   {exp_gnt != NONE, ew, (exp_gnt != NONE) ? exp_addr : 4'h0, ew ? exp_wdata : 8'h00});
        chk("rvalid", {c_rvalid, d_rvalid, (c_rvalid | d_rvalid) ? rdata : 8'h00},
                      {exp_rv_c, exp_rv_d, erv ? exp_rdata : 8'h00});
        chk("busy", busy, (exp_gnt != NONE) | erv);
        chk("cnt", {c_cnt, d_cnt}, exp_cnt_vec());
        if (c_gnt) $display("%0t calc %s addr=%h data=%h", $time, mem_we ? "wr" : "rd", mem_addr, mem_wdata);
        if (d_gnt) $display("%0t disp rd addr=%h", $time, mem_addr);
    endtask

    // Decide the grant for the inputs just applied, from the arbitration rules.
    task automatic predict();
        bit c_ok, d_ok, c_first;
        c_ok = c_req && (phase == 2'd1 || phase == 2'd2);
        d_ok = d_req && (phase == 2'd1 || phase == 2'd2);
        if (c_ok && d_ok) begin
            c_first = (phase == 2'd1);
            if (streak >= HOLD_MAX) begin
                exp_gnt = c_first ? GD : GC;
                streak  = 0;
            end else begin
                exp_gnt = c_first ? GC : GD;
                streak++;
            end
        end else begin
            streak  = 0;
            exp_gnt = c_ok ? GC : (d_ok ? GD : NONE);
        end
        exp_we    = (exp_gnt == GC) ? c_we : 1'b0;
        exp_addr  = (exp_gnt == GC) ? c_addr : d_addr;
        exp_wdata = c_wdata;
    endtask

    // mode 0: drop a request once granted; 1: hold requests; 2: random traffic.
    task automatic cycle(input int mode);
        @(negedge clk);
        check_outputs();
        exp_rv_c  = (exp_gnt == GC) && !exp_we;
        exp_rv_d  = (exp_gnt == GD);
        exp_rdata = ref_mem[exp_addr];
        if (exp_gnt == GC && exp_we) ref_mem[exp_addr] = exp_wdata;
        if (exp_gnt == GC && exp_ccnt != 16'hFFFF) exp_ccnt++;
        if (exp_gnt == GD && exp_dcnt != 16'hFFFF) exp_dcnt++;
        if (mode != 1) begin
            if (exp_gnt == GC) drv_c_req = 1'b0;
            if (exp_gnt == GD) drv_d_req = 1'b0;
        end
        if (mode == 2) begin
            if (!drv_c_req && $urandom_range(1, 0) == 1) begin
                drv_c_req   = 1'b1;
                drv_c_we    = 1'($urandom);
                drv_c_addr  = 4'($urandom);
                drv_c_wdata = 8'($urandom);
            end
            if (!drv_d_req && $urandom_range(1, 0) == 1) begin
                drv_d_req  = 1'b1;
                drv_d_addr = 4'($urandom);
            end
            if ($urandom_range(15, 0) == 0)
                drv_phase = ($urandom_range(3, 0) == 0) ? 2'($urandom) : 2'($urandom_range(2, 1));
        end
        phase   = drv_phase;
        c_req   = drv_c_req;
        c_we    = drv_c_we;
        c_addr  = drv_c_addr;
        c_wdata = drv_c_wdata;
        d_req   = drv_d_req;
        d_addr  = drv_d_addr;
        predict();
    endtask

    task automatic wait_sig(input int sel, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            cycle(0);
            seen = sig(sel);
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic idle(input int n);
        drv_c_req = 1'b0;
        drv_d_req = 1'b0;
        for (int i = 0; i < n; i++) cycle(0);
    endtask

    // Asserted between edges; outputs must clear without waiting for a clock.
    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_async", out_vec(), 64'd0);
        drv_phase = '0; drv_c_req = 1'b0; drv_c_we = 1'b0; drv_d_req = 1'b0;
        drv_c_addr = '0; drv_d_addr = '0; drv_c_wdata = '0;
        phase = '0; c_req = 1'b0; c_we = 1'b0; d_req = 1'b0;
        c_addr = '0; d_addr = '0; c_wdata = '0;
        exp_gnt = NONE; exp_we = 1'b0; exp_rv_c = 1'b0; exp_rv_d = 1'b0;
        exp_ccnt = '0; exp_dcnt = '0; streak = 0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_hold", out_vec(), 64'd0);
        end
        rst = 1'b1;
    endtask

    initial begin
        logic [9:0] pat;
        int         ngnt;
        int         nc;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        #2;
        reset_pulse();

        // Phase 0 blocks everything.
        drv_phase = 2'd0; drv_c_req = 1'b1; drv_d_req = 1'b1;
        ngnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            ngnt += int'(c_gnt | d_gnt | mem_en | busy);
        end
        chk("t1_phase0_quiet", ngnt, 0);
        idle(2);

        // Single calc read.
        mem[3] = 8'hA5; ref_mem[3] = 8'hA5;
        drv_phase = 2'd1; drv_c_req = 1'b1; drv_c_we = 1'b0; drv_c_addr = 4'd3;
        cycle(0);
        cycle(0);
        chk("t2_gnt", {c_gnt, mem_en, mem_we}, 3'b110);
        cycle(0);
        chk("t2_rdata", {c_rvalid, rdata}, {1'b1, 8'hA5});
        idle(2);

        // Both held in phase 1: the display side gets every fifth grant.
        drv_c_req = 1'b1; drv_d_req = 1'b1; drv_c_we = 1'b0;
        cycle(1);
        nc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1);
            pat[i] = d_gnt;
            nc += int'(c_gnt);
        end
        chk("t3_pattern", pat, 10'b1000010000);
        chk("t3_calc_grants", nc, 8);
        idle(2);

        // Phase 2: display reads old value before the calc write lands.
        mem[5] = 8'h11; ref_mem[5] = 8'h11;
        drv_phase = 2'd2;
        drv_c_req = 1'b1; drv_c_we = 1'b1; drv_c_addr = 4'd5; drv_c_wdata = 8'h3C;
        drv_d_req = 1'b1; drv_d_addr = 4'd5;
        wait_sig(S_DGNT, "t4_disp_first");
        chk("t4_calc_waits", c_gnt, 1'b0);
        wait_sig(S_DRV, "t4_disp_rvalid");
        chk("t4_old_value", rdata, 8'h11);
        chk("t4_calc_write", {c_gnt, mem_we, mem_wdata}, {2'b11, 8'h3C});
        idle(1);
        drv_d_req = 1'b1; drv_d_addr = 4'd5;
        wait_sig(S_DRV, "t4_reread_rvalid");
        chk("t4_new_value", rdata, 8'h3C);
        idle(2);

        // Read in flight survives a switch to phase 3.
        drv_phase = 2'd1; drv_c_req = 1'b1; drv_c_we = 1'b0; drv_c_addr = 4'd3;
        cycle(0);
        drv_phase = 2'd3;
        wait_sig(S_CRV, "t5_rvalid");
        chk("t5_rdata", rdata, 8'hA5);
        drv_c_req = 1'b1; drv_d_req = 1'b1;
        ngnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1);
            ngnt += int'(c_gnt | d_gnt);
        end
        chk("t5_no_grants", ngnt, 0);
        idle(2);

        // Random traffic with a reset dropped into the middle.
        drv_phase = 2'd1;
        for (int i = 0; i < 300; i++) cycle(2);
        reset_pulse();
        drv_phase = 2'd2;
        for (int i = 0; i < 300; i++) cycle(2);

        // First grant after a reset arrives one cycle after the request.
        reset_pulse();
        drv_phase = 2'd1; drv_c_req = 1'b1; drv_c_we = 1'b0; drv_c_addr = 4'd0;
        cycle(0);
        cycle(0);
        chk("t6_first_gnt", c_gnt, 1'b1);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
